ct_had_pcfifo_rdctl: RTL
========================

# ct_had_pcfifo_rdctl

Debug-side read controller for the HAD PC FIFO. It generates the FIFO write and pop controls and serves debugger reads of the 64-bit FIFO output as two 32-bit words over the HAD register read path. It sits between the HAD register file and the PC FIFO, downstream of the FIFO data output.

## Interface
Parameters:
- DATAW, 64, width of the FIFO data input.
- RDW, 32, width of the register read bus.
- DEPTH, 16, FIFO depth; sets the saturation value of the pop counter.

Ports:
- cpuclk  in  1  clock.
- cpurst_b  in  1  reset, asynchronous, active-low.
- had_dbg_mode  in  1  core is in debug mode.
- regs_pcfifo_trace_en  in  1  PC recording enable, from the HCR.
- regs_pcfifo_rd_req  in  1  one-cycle debugger read request.
- regs_pcfifo_rd_sel  in  1  word select for the request: 0 = low word (pops the FIFO), 1 = high word (no pop).
- pcfifo_regs_data  in  DATAW  FIFO output word. It is valid in the cycle after ctrl_pcfifo_ren.
- ctrl_pcfifo_wen  out  1  FIFO write enable.
- ctrl_pcfifo_ren  out  1  FIFO pop, a one-cycle pulse.
- pcfifo_rd_ack  out  1  one-cycle read completion.
- pcfifo_rd_data  out  RDW  read data. It is valid only while ack is high and is 0 otherwise.
- pcfifo_rd_err  out  1  one-cycle pulse: a request arrived while the controller was busy.
- pcfifo_rd_cnt  out  5  number of pops since the last debug entry.

## Operation
- Write enable: ctrl_pcfifo_wen is registered from regs_pcfifo_trace_en & ~had_dbg_mode. Entering debug mode therefore freezes FIFO contents one cycle later.
- FSM states are IDLE, POP, WAIT and DONE.
- Transitions out of IDLE, accepted only when regs_pcfifo_rd_req = 1:
  - rd_sel = 0 goes to POP.
  - rd_sel = 1 goes to DONE.
  - rd_sel is latched into sel_q on acceptance.
- POP: ctrl_pcfifo_ren = 1. Next state is WAIT.
- WAIT: pcfifo_regs_data is captured into the 64-bit hold register. Next state is DONE.
- DONE: pcfifo_rd_ack = 1 and pcfifo_rd_data = sel_q ? hold[63:32] : hold[31:0]. Next state is IDLE.
- A request in POP, WAIT or DONE is dropped. pcfifo_rd_err pulses in the following cycle and the FSM is unaffected.
- A high-word read returns the hold register from the most recent low-word read. If no low-word read has happened since reset, it returns 0.
- Pop counter:
  - Cleared on the rising edge of had_dbg_mode (previous value 0, current value 1).
  - Otherwise incremented by 1 for each POP cycle.
  - Saturates at DEPTH (5'd16).
  - A clear takes priority over an increment in the same cycle.
- The FIFO handles pops on an empty FIFO and simultaneous write/pop. This block adds no gating to ren.

## Timing
- Reset values (all asynchronous): state = IDLE, ctrl_pcfifo_wen = 0, ctrl_pcfifo_ren = 0, pcfifo_rd_ack = 0, pcfifo_rd_data = 0, pcfifo_rd_err = 0, pcfifo_rd_cnt = 0, hold = 0, sel_q = 0.
- Low-word read, with the request high in cycle 0:
  - cycle 1: ren = 1.
  - cycle 2: capture.
  - cycle 3: ack with data.
  - Latency is 3 cycles.
- High-word read, with the request high in cycle 0: ack with data in cycle 1. Latency is 1 cycle.
- A new request is accepted at the earliest in the cycle after DONE. Back-to-back low-word reads therefore run at a rate of one per 4 cycles.
- Write enable: a trace_en or had_dbg_mode change in cycle N is reflected on wen in cycle N+1.
- Asserting reset mid-transaction aborts the transaction with no ack and no err. A ren already issued is not undone.

## Configuration
- HAD_PCFIFO_RDCNT_EN:
  - Defined: the pop counter is built as described above.
  - Undefined: the counter logic is removed and pcfifo_rd_cnt is tied to 5'd0. All other behaviour is unchanged.

## Test plan
- Reset then idle: all outputs 0. With trace_en = 1 and dbg_mode = 0, wen = 1 one cycle later.
- Low-word read, with FIFO output 0x0000_0001_8000_1234: ren in cycle 1, ack in cycle 3, rd_data = 0x8000_1234.
- High-word read following that low-word read: ack one cycle after the request, rd_data = 0x0000_0001, no ren pulse.
- Request in the cycle after a low-word request (FSM in POP): err pulses once, only one ack occurs, and its data is the low word of the first read.
- Debug entry, then 20 low-word reads (with the macro defined): wen drops one cycle after entry. rd_cnt steps 0 to 16 and then holds at 16. Leaving and re-entering debug clears rd_cnt to 0.
- Reset asserted while in WAIT: no ack follows, and a subsequent high-word read returns 0.

Source files
------------

// File: rtl/ct_had_pcfifo_rdctl.sv
// ct_had_pcfifo_rdctl
// Debug-side read controller for the HAD PC FIFO. Generates the FIFO write
// enable and pop, and returns the 64-bit FIFO output to the debugger as two
// 32-bit words: the low-word read pops and captures, the high-word read
// returns the upper half of the last capture.
//
// Build option: define HAD_PCFIFO_RDCNT_EN to build the pop counter on
// pcfifo_rd_cnt. Without it the counter is removed and the port reads 0.
module ct_had_pcfifo_rdctl #(
  parameter int DATAW = 64,
  parameter int RDW   = 32,
  parameter int DEPTH = 16
) (
  input  logic             cpuclk,
  input  logic             cpurst_b,
  input  logic             had_dbg_mode,
  input  logic             regs_pcfifo_trace_en,
  input  logic             regs_pcfifo_rd_req,
  input  logic             regs_pcfifo_rd_sel,
  input  logic [DATAW-1:0] pcfifo_regs_data,
  output logic             ctrl_pcfifo_wen,
  output logic             ctrl_pcfifo_ren,
  output logic             pcfifo_rd_ack,
  output logic [RDW-1:0]   pcfifo_rd_data,
  output logic             pcfifo_rd_err,
  output logic [4:0]       pcfifo_rd_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state;
  logic             sel_q;
  logic [DATAW-1:0] hold;

  // Word select: 1 = upper half, 0 = lower half of a captured FIFO word.
  function automatic logic [RDW-1:0] pick_word(input logic sel,
                                               input logic [DATAW-1:0] word);
    return sel ? word[2*RDW-1:RDW] : word[RDW-1:0];
  endfunction

  // Recording runs only while tracing is enabled and the core is not halted;
  // the registered enable freezes the FIFO one cycle after debug entry.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      ctrl_pcfifo_wen <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments on all state so every register sees
      // the pre-edge values of the others, whatever the statement order.
      ctrl_pcfifo_wen <= regs_pcfifo_trace_en & ~had_dbg_mode;
    end
  end

  // Read FSM with registered ren/ack/data/err. The response for a word is
  // loaded on the edge that enters DONE, so ack is high exactly in DONE.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state           <= S_IDLE;
      sel_q           <= 1'b0;
      // NOTE: the hold register is reset too, because a high-word read with
      // no prior low-word read must return a defined 0.
      hold            <= '0;
      ctrl_pcfifo_ren <= 1'b0;
      pcfifo_rd_ack   <= 1'b0;
      pcfifo_rd_data  <= '0;
      pcfifo_rd_err   <= 1'b0;
    end else begin
      // Pulse outputs default low; data is zero outside ack.
      ctrl_pcfifo_ren <= 1'b0;
      pcfifo_rd_ack   <= 1'b0;
      pcfifo_rd_data  <= '0;
      pcfifo_rd_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (regs_pcfifo_rd_req) begin
            sel_q <= regs_pcfifo_rd_sel;
            if (regs_pcfifo_rd_sel) begin
              // High word comes straight from the last capture.
              state          <= S_DONE;
              pcfifo_rd_ack  <= 1'b1;
              pcfifo_rd_data <= pick_word(1'b1, hold);
            end else begin
              state           <= S_POP;
              ctrl_pcfifo_ren <= 1'b1;
            end
          end
        end
        S_POP: begin
          pcfifo_rd_err <= regs_pcfifo_rd_req;
          state         <= S_WAIT;
        end
        S_WAIT: begin
          // FIFO output is valid now, one cycle after the pop.
          pcfifo_rd_err  <= regs_pcfifo_rd_req;
          hold           <= pcfifo_regs_data;
          pcfifo_rd_ack  <= 1'b1;
          pcfifo_rd_data <= pick_word(sel_q, pcfifo_regs_data);
          state          <= S_DONE;
        end
        S_DONE: begin
          pcfifo_rd_err <= regs_pcfifo_rd_req;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HAD_PCFIFO_RDCNT_EN
  localparam logic [4:0] CNT_MAX = 5'(DEPTH);

  logic dbg_q;

  // Pops since the last debug entry; a debug-entry clear beats a pop in the
  // same cycle, and the count sticks at the FIFO depth.
  always_ff @(posedge cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      dbg_q         <= 1'b0;
      pcfifo_rd_cnt <= 5'd0;
    end else begin
      dbg_q <= had_dbg_mode;
      if (had_dbg_mode && !dbg_q) begin
        pcfifo_rd_cnt <= 5'd0;
      end else if (state == S_POP && pcfifo_rd_cnt != CNT_MAX) begin
        pcfifo_rd_cnt <= pcfifo_rd_cnt + 5'd1;
      end
    end
  end
`else
  // Counter not built. DEPTH only sizes the counter; it is referenced here
  // so both builds keep an identical, fully used parameter list.
  assign pcfifo_rd_cnt = 5'(DEPTH) & 5'd0;
`endif

endmodule
